// File: rtl/ballot_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ballot_display_pkg
// Description : Display codes, controller state encoding and the channel-label
//               helper shared by the ballot display controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ballot_display_pkg;

    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_C     = 4'd11;
    localparam logic [3:0] CODE_N     = 4'd12;

    localparam int CHAN_W = 4;

    typedef enum logic [1:0] {
        ST_ENTRY      = 2'd0,
        ST_RES_MANUAL = 2'd1,
        ST_RES_AUTO   = 2'd2
    } disp_state_t;

    // Candidates show their own number; the null channel shows 'N'.
    function automatic logic [3:0] chan_label(input logic [CHAN_W-1:0] chan,
                                              input logic [CHAN_W-1:0] null_chan);
        return (chan == null_chan) ? CODE_N : chan;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : dwell_timer
// Description : Counts cycles spent on one channel; pulses expire on the last
//               cycle of each DWELL_CYCLES-long dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer #(
    parameter int DWELL_CYCLES = 50000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic restart,
    output logic expire
);

    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign expire = !clear && (r_count == c_last);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear || restart || expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ballot_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ballot_display_ctrl
// Description : Multiplexes vote entry and per-channel tallies onto NUM_POS
//               BCD display positions; manual or timed auto-scroll results.
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading tally zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module ballot_display_ctrl
    import ballot_display_pkg::*;
#(
    parameter int NUM_CAND     = 4,
    parameter int CNT_DIGITS   = 6,
    parameter int ENTRY_DIGITS = 4,
    parameter int NUM_POS      = 8,
    parameter int DWELL_CYCLES = 50000000
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  finish,
    input  logic                                  auto_scroll,
    input  logic [3:0]                            sel_chan,
    input  logic                                  next_pulse,
    input  logic [$clog2(ENTRY_DIGITS+1)-1:0]     entry_count,
    input  logic [4*ENTRY_DIGITS-1:0]             entry_digits,
    input  logic [4*CNT_DIGITS*(NUM_CAND+1)-1:0]  tallies,
    output logic [4*NUM_POS-1:0]                  bcd_out,
    output logic [3:0]                            shown_chan,
    output logic                                  result_valid
);

    localparam int ECW = $clog2(ENTRY_DIGITS+1);
    localparam int TW  = 4*CNT_DIGITS;
    localparam int c_field_base = NUM_POS - ENTRY_DIGITS;
    localparam logic [3:0] c_null_chan = 4'(NUM_CAND);
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit c_lz_blank = 1'b1;
`else
    localparam bit c_lz_blank = 1'b0;
`endif

    disp_state_t          r_state;
    disp_state_t          w_state_next;
    logic [3:0]           r_auto_chan;
    logic [3:0]           w_auto_chan_next;
    logic                 w_enter_auto;
    logic                 w_timer_clear;
    logic                 w_timer_restart;
    logic                 w_expire;

    logic [4*NUM_POS-1:0] r_bcd;
    logic [3:0]           r_shown;
    logic                 r_valid;
    logic [4*NUM_POS-1:0] w_bcd;
    logic [3:0]           w_shown;
    logic                 w_valid;
    logic [3:0]           w_chan;
    logic [TW-1:0]        w_tally;
    logic [3:0]           w_digit;
    logic                 w_lead;
    logic [ECW-1:0]       w_count_sat;

    dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (w_timer_clear),
        .restart (w_timer_restart),
        .expire  (w_expire)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_ENTRY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_ENTRY;
        if (finish) begin
            w_state_next = auto_scroll ? ST_RES_AUTO : ST_RES_MANUAL;
        end
    end

    assign w_enter_auto    = (w_state_next == ST_RES_AUTO) && (r_state != ST_RES_AUTO);
    assign w_timer_clear   = (w_state_next != ST_RES_AUTO);
    assign w_timer_restart = w_enter_auto || next_pulse;

    // A pulse landing on dwell expiry still yields a single step.
    always_comb begin
        w_auto_chan_next = r_auto_chan;
        if ((w_state_next != ST_RES_AUTO) || w_enter_auto) begin
            w_auto_chan_next = '0;
        end else if (next_pulse || w_expire) begin
            w_auto_chan_next = (r_auto_chan == c_null_chan) ? 4'd0 : r_auto_chan + 4'd1;
        end
    end

    // Display image is built from the upcoming state so outputs lag inputs by one cycle.
    always_comb begin
        w_bcd       = {NUM_POS{CODE_BLANK}};
        w_shown     = '0;
        w_valid     = 1'b0;
        w_tally     = '0;
        w_digit     = '0;
        w_lead      = 1'b1;
        w_count_sat = (entry_count > ECW'(ENTRY_DIGITS)) ? ECW'(ENTRY_DIGITS) : entry_count;
        case (w_state_next)
            ST_RES_MANUAL: w_chan = sel_chan;
            ST_RES_AUTO:   w_chan = w_auto_chan_next;
            default:       w_chan = '0;
        endcase

        if (w_state_next == ST_ENTRY) begin
            for (int i = 0; i < ENTRY_DIGITS; i++) begin
                if (i < int'(w_count_sat)) begin
                    w_bcd[(c_field_base+i)*4 +: 4] = entry_digits[i*4 +: 4];
                end
            end
        end else begin
            w_shown = w_chan;
            if (w_chan <= c_null_chan) begin
                w_valid = 1'b1;
                for (int c = 0; c <= NUM_CAND; c++) begin
                    if (w_chan == 4'(c)) begin
                        w_tally = tallies[c*TW +: TW];
                    end
                end
                w_bcd[3:0] = CODE_C;
                w_bcd[7:4] = chan_label(w_chan, c_null_chan);
                for (int j = 0; j < CNT_DIGITS; j++) begin
                    w_digit = w_tally[(CNT_DIGITS-1-j)*4 +: 4];
                    if (c_lz_blank && w_lead && (w_digit == 4'd0) && (j != CNT_DIGITS-1)) begin
                        w_bcd[(2+j)*4 +: 4] = CODE_BLANK;
                    end else begin
                        w_bcd[(2+j)*4 +: 4] = w_digit;
                        w_lead              = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_auto_chan <= '0;
            r_bcd       <= {NUM_POS{CODE_BLANK}};
            r_shown     <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_auto_chan <= w_auto_chan_next;
            r_bcd       <= w_bcd;
            r_shown     <= w_shown;
            r_valid     <= w_valid;
        end
    end

    assign bcd_out      = r_bcd;
    assign shown_chan   = r_shown;
    assign result_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_ballot_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ballot_display_ctrl
// Description : Self-checking bench: vector table, scroll corner cases and
//               randomized traffic against a decimal reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ballot_display_ctrl;

    localparam int NUM_CAND     = 4;
    localparam int CNT_DIGITS   = 6;
    localparam int ENTRY_DIGITS = 4;
    localparam int NUM_POS      = 8;
    localparam int DWELL        = 4;
    localparam int NCH          = NUM_CAND + 1;
    localparam logic [31:0] ALL_BLANK = 32'hAAAAAAAA;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
    localparam logic [31:0] E_CH1  = 32'h0AAAAA1B;
    localparam logic [31:0] E_CH2  = 32'h751AAA2B;
    localparam logic [31:0] E_NULL = 32'h3AAAAACB;
`else
    localparam bit LZB = 1'b0;
    localparam logic [31:0] E_CH1  = 32'h0000001B;
    localparam logic [31:0] E_CH2  = 32'h7510002B;
    localparam logic [31:0] E_NULL = 32'h300000CB;
`endif

    logic                          clock = 1'b0;
    logic                          reset_n;
    logic                          finish;
    logic                          auto_scroll;
    logic [3:0]                    sel_chan;
    logic                          next_pulse;
    logic [2:0]                    entry_count;
    logic [15:0]                   entry_digits;
    logic [4*CNT_DIGITS*NCH-1:0]   tallies;
    logic [31:0]                   bcd_out;
    logic [3:0]                    shown_chan;
    logic                          result_valid;

    ballot_display_ctrl #(
        .NUM_CAND     (NUM_CAND),
        .CNT_DIGITS   (CNT_DIGITS),
        .ENTRY_DIGITS (ENTRY_DIGITS),
        .NUM_POS      (NUM_POS),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .finish       (finish),
        .auto_scroll  (auto_scroll),
        .sel_chan     (sel_chan),
        .next_pulse   (next_pulse),
        .entry_count  (entry_count),
        .entry_digits (entry_digits),
        .tallies      (tallies),
        .bcd_out      (bcd_out),
        .shown_chan   (shown_chan),
        .result_valid (result_valid)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int tally_val [NCH];

    // Reference model: mode 0 entry, 1 manual, 2 auto
    int          m_mode = 0;
    int          m_chan = 0;
    int          m_elapsed = 0;
    logic [31:0] m_bcd;
    logic [3:0]  m_shown;
    logic        m_valid;

    typedef struct {
        logic        fin;
        logic        aut;
        logic [3:0]  sel;
        logic        np;
        logic [2:0]  ecnt;
        logic [15:0] edig;
        logic [31:0] ebcd;
        logic [3:0]  eshown;
        logic        evalid;
    } vec_t;
    vec_t vecs [11];

    function automatic int pow10(int p);
        int r = 1;
        for (int i = 0; i < p; i++) r = r * 10;
        return r;
    endfunction

    // Tally right-aligned at the last position, label in positions 0 and 1.
    function automatic logic [31:0] result_image(int c, int value);
        logic [31:0] img = ALL_BLANK;
        int pos;
        img[3:0] = 4'hB;
        img[7:4] = (c == NUM_CAND) ? 4'hC : 4'(c);
        for (int p = 0; p < CNT_DIGITS; p++) begin
            pos = 1 + CNT_DIGITS - p;
            if (!LZB || p == 0 || value >= pow10(p))
                img[pos*4 +: 4] = 4'((value / pow10(p)) % 10);
        end
        return img;
    endfunction

    task automatic apply_tallies();
        for (int c = 0; c < NCH; c++)
            for (int p = 0; p < CNT_DIGITS; p++)
                tallies[(c*CNT_DIGITS+p)*4 +: 4] = 4'((tally_val[c] / pow10(p)) % 10);
    endtask

    task automatic model_step();
        int mode;
        int n;
        if (!reset_n) begin
            m_mode = 0; m_chan = 0; m_elapsed = 0;
            m_bcd = ALL_BLANK; m_shown = 4'd0; m_valid = 1'b0;
            return;
        end
        mode = !finish ? 0 : (auto_scroll ? 2 : 1);
        if (mode == 2) begin
            if (m_mode != 2) begin
                m_chan = 0; m_elapsed = 0;
            end else if (next_pulse || m_elapsed == DWELL-1) begin
                m_chan = (m_chan + 1) % NCH; m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end
        m_mode = mode;
        m_bcd = ALL_BLANK; m_shown = 4'd0; m_valid = 1'b0;
        if (mode == 0) begin
            n = (int'(entry_count) > ENTRY_DIGITS) ? ENTRY_DIGITS : int'(entry_count);
            for (int i = 0; i < n; i++)
                m_bcd[(NUM_POS-ENTRY_DIGITS+i)*4 +: 4] = entry_digits[i*4 +: 4];
        end else if (mode == 1) begin
            m_shown = sel_chan;
            if (int'(sel_chan) <= NUM_CAND) begin
                m_bcd = result_image(int'(sel_chan), tally_val[sel_chan]);
                m_valid = 1'b1;
            end
        end else begin
            m_shown = 4'(m_chan);
            m_bcd = result_image(m_chan, tally_val[m_chan]);
            m_valid = 1'b1;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(string tag);
        @(posedge clock);
        model_step();
        #1;
        check({tag, ".bcd"}, bcd_out, m_bcd);
        check({tag, ".shown"}, 32'(shown_chan), 32'(m_shown));
        check({tag, ".valid"}, 32'(result_valid), 32'(m_valid));
    endtask

    task automatic fresh_auto();
        finish = 1'b1; auto_scroll = 1'b0; next_pulse = 1'b0;
        tick("pre_auto");
        auto_scroll = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; finish = 1'b1; auto_scroll = 1'b1; next_pulse = 1'b1;
        sel_chan = 4'd0; entry_count = 3'd0; entry_digits = 16'h0;
        tally_val = '{123456, 0, 157, 907050, 3};
        tallies = '0;
        apply_tallies();

        // Reset overrides active result inputs
        for (int k = 0; k < 3; k++) tick("reset");
        check("reset_bcd", bcd_out, ALL_BLANK);
        check("reset_shown", 32'(shown_chan), 32'd0);
        check("reset_valid", 32'(result_valid), 32'd0);
        reset_n = 1'b1;

        vecs[0]  = '{1'b0, 1'b0, 4'd0, 1'b0, 3'd2, 16'h0031, 32'hAA31AAAA, 4'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'd3, 1'b0, 3'd0, 16'h5555, ALL_BLANK,    4'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 4'd1, 1'b0, 3'd4, 16'h9876, 32'h9876AAAA, 4'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'd0, 1'b1, 3'd7, 16'h4321, 32'h4321AAAA, 4'd0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 4'd2, 1'b0, 3'd2, 16'h0031, E_CH2,        4'd2, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 4'd9, 1'b0, 3'd2, 16'h0031, ALL_BLANK,    4'd9, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'd4, 1'b0, 3'd0, 16'h0000, E_NULL,       4'd4, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 4'd5, 1'b0, 3'd0, 16'h0000, ALL_BLANK,    4'd5, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 16'h0000, 32'h6543210B, 4'd0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 4'd1, 1'b0, 3'd0, 16'h0000, E_CH1,        4'd1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 4'd3, 1'b1, 3'd0, 16'h0000, 32'h0507093B, 4'd3, 1'b1};
        for (int v = 0; v < 11; v++) begin
            finish = vecs[v].fin; auto_scroll = vecs[v].aut; sel_chan = vecs[v].sel;
            next_pulse = vecs[v].np; entry_count = vecs[v].ecnt; entry_digits = vecs[v].edig;
            tick("vec_model");
            check($sformatf("vec%0d_bcd", v), bcd_out, vecs[v].ebcd);
            check($sformatf("vec%0d_shown", v), 32'(shown_chan), 32'(vecs[v].eshown));
            check($sformatf("vec%0d_valid", v), 32'(result_valid), 32'(vecs[v].evalid));
        end

        // Full scroll with wrap from null channel back to 0
        fresh_auto();
        for (int k = 0; k < 24; k++) begin
            tick("scroll");
            check($sformatf("scroll_k%0d", k), 32'(shown_chan), 32'((k / DWELL) % NCH));
        end

        // Pulse coinciding with dwell expiry steps once
        fresh_auto();
        for (int k = 0; k < 9; k++) begin
            next_pulse = (k == 4);
            tick("pulse_exp");
            check($sformatf("pulse_exp_k%0d", k), 32'(shown_chan), (k < 4) ? 32'd0 : (k < 8) ? 32'd1 : 32'd2);
        end

        // Early pulse gives the new channel a full dwell
        fresh_auto();
        for (int k = 0; k < 7; k++) begin
            next_pulse = (k == 2);
            tick("pulse_early");
            check($sformatf("pulse_early_k%0d", k), 32'(shown_chan), (k < 2) ? 32'd0 : (k < 6) ? 32'd1 : 32'd2);
        end
        next_pulse = 1'b0;

        // Reset while scrolling at channel 3, then restart from channel 0
        fresh_auto();
        for (int k = 0; k < 13; k++) tick("to_ch3");
        check("mid_scroll_ch3", 32'(shown_chan), 32'd3);
        reset_n = 1'b0;
        tick("midreset");
        check("midreset_bcd", bcd_out, ALL_BLANK);
        check("midreset_shown", 32'(shown_chan), 32'd0);
        check("midreset_valid", 32'(result_valid), 32'd0);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick("restart");
            check($sformatf("restart_k%0d", k), 32'(shown_chan), (k < DWELL) ? 32'd0 : 32'd1);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) finish = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) auto_scroll = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 7) == 0) sel_chan = 4'($urandom_range(0, 15));
            next_pulse = ($urandom_range(0, 9) == 0);
            entry_count = 3'($urandom_range(0, 7));
            entry_digits = 16'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                tally_val[$urandom_range(0, NCH-1)] =
                    ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 999999)) : int'($urandom_range(0, 99));
                apply_tallies();
            end
            reset_n = ($urandom_range(0, 199) != 0);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
